// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with freeze, flush, bubble and operand forwarding
module id_exe_stage_reg #(
    parameter int WORD_LEN        = 32,
    parameter int REG_ADDRESS_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       flush,
    input  logic                       insert_bubble,
    input  logic                       ID_wb_en,
    input  logic                       ID_mem_r_en,
    input  logic                       ID_mem_w_en,
    input  logic                       ID_b,
    input  logic                       ID_s,
    input  logic                       ID_imm,
    input  logic [3:0]                 ID_exe_cmd,
    input  logic [WORD_LEN-1:0]        ID_pc,
    input  logic [WORD_LEN-1:0]        ID_val_rn,
    input  logic [WORD_LEN-1:0]        ID_val_rm,
    input  logic [11:0]                ID_shift_operand,
    input  logic [23:0]                ID_signed_imm_24,
    input  logic [REG_ADDRESS_LEN-1:0] ID_dst,
    input  logic [REG_ADDRESS_LEN-1:0] ID_src1,
    input  logic [REG_ADDRESS_LEN-1:0] ID_src2,
    input  logic [3:0]                 ID_sr,
    input  logic [1:0]                 sel_src1,
    input  logic [1:0]                 sel_src2,
    input  logic [WORD_LEN-1:0]        MEM_alu_result,
    input  logic [WORD_LEN-1:0]        WB_value,
    output logic                       EXE_wb_en,
    output logic                       EXE_mem_r_en,
    output logic                       EXE_mem_w_en,
    output logic                       EXE_b,
    output logic                       EXE_s,
    output logic                       EXE_imm,
    output logic [3:0]                 EXE_exe_cmd,
    output logic [WORD_LEN-1:0]        EXE_pc,
    output logic [WORD_LEN-1:0]        EXE_val_rn,
    output logic [WORD_LEN-1:0]        EXE_val_rm,
    output logic [11:0]                EXE_shift_operand,
    output logic [23:0]                EXE_signed_imm_24,
    output logic [REG_ADDRESS_LEN-1:0] EXE_dst,
    output logic [REG_ADDRESS_LEN-1:0] EXE_src1,
    output logic [REG_ADDRESS_LEN-1:0] EXE_src2,
    output logic [3:0]                 EXE_sr,
    output logic                       EXE_valid,
    output logic [WORD_LEN-1:0]        fwd_val_rn,
    output logic [WORD_LEN-1:0]        fwd_val_rm
);
    // valid bit + six control bits + cmd + three words + shifter + offset + three addresses + flags
    localparam int BUS_W = 51 + 3 * WORD_LEN + 3 * REG_ADDRESS_LEN;
    logic [BUS_W-1:0] id_bus, exe_bus;
    // all-zero slot is a NOP, so flush/bubble/reset just clear the whole bundle
    assign id_bus = {1'b1, ID_wb_en, ID_mem_r_en, ID_mem_w_en, ID_b, ID_s, ID_imm, ID_exe_cmd,
                     ID_pc, ID_val_rn, ID_val_rm, ID_shift_operand, ID_signed_imm_24,
                     ID_dst, ID_src1, ID_src2, ID_sr};
    assign {EXE_valid, EXE_wb_en, EXE_mem_r_en, EXE_mem_w_en, EXE_b, EXE_s, EXE_imm, EXE_exe_cmd,
            EXE_pc, EXE_val_rn, EXE_val_rm, EXE_shift_operand, EXE_signed_imm_24,
            EXE_dst, EXE_src1, EXE_src2, EXE_sr} = exe_bus;
    // stage register: freeze holds, flush or bubble loads a NOP, otherwise capture ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) exe_bus <= '0;
        else if (!freeze) exe_bus <= (flush || insert_bubble) ? '0 : id_bus;
    end
    // forwarding mux: 01 = MEM, 10 = WB, 00/11 = registered operand
    always_comb begin
        fwd_val_rn = (sel_src1 == 2'b01) ? MEM_alu_result : (sel_src1 == 2'b10) ? WB_value : EXE_val_rn;
        fwd_val_rm = (sel_src2 == 2'b01) ? MEM_alu_result : (sel_src2 == 2'b10) ? WB_value : EXE_val_rm;
    end
endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the ARM ID stage and the EXE stage.
- Latches the decoded instruction's control, operands and register addresses.
- Presents EXE_src1/EXE_src2 to the forwarding unit and consumes its sel_src1/sel_src2 to produce the forwarded ALU operands.
- Supports freeze (memory stall), flush (taken branch) and bubble insertion (unresolved RAW hazard).

Parameters:
- WORD_LEN, 32, data/PC width.
- REG_ADDRESS_LEN, 4, register-file address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- freeze  input  1  hold all registered state.
- flush  input  1  replace captured instruction with NOP.
- insert_bubble  input  1  hazard detected and not ignored by forwarding; capture NOP.
- ID_wb_en, ID_mem_r_en, ID_mem_w_en, ID_b, ID_s, ID_imm  input  1 each  decoded control bits.
- ID_exe_cmd  input  4  ALU command.
- ID_pc  input  WORD_LEN  PC+4 of the instruction.
- ID_val_rn, ID_val_rm  input  WORD_LEN  register-file read values.
- ID_shift_operand  input  12  shifter operand field.
- ID_signed_imm_24  input  24  branch offset.
- ID_dst, ID_src1, ID_src2  input  REG_ADDRESS_LEN  destination/source register numbers.
- ID_sr  input  4  status flags {N,Z,C,V} at decode.
- sel_src1, sel_src2  input  2  forwarding selects from the forwarding unit.
- MEM_alu_result  input  WORD_LEN  value in MEM stage.
- WB_value  input  WORD_LEN  value in WB stage.
- EXE_* (one per ID_* field above, same width)  output  registered copies.
- EXE_valid  output  1  captured slot holds a real instruction.
- fwd_val_rn, fwd_val_rm  output  WORD_LEN  forwarded operands to ALU / Val2 generator.

Behaviour:
- All EXE_* registers and EXE_valid update on rising clk.
- rst asserted: every EXE_* output and EXE_valid go to 0 immediately, independent of clk. Zero equals a NOP: no wb, no mem, no branch, no S.
- Per-edge priority: freeze > flush > insert_bubble > load.
- freeze=1: all registers hold, including EXE_valid.
- flush=1 (freeze=0): all fields load 0 and EXE_valid=0.
- insert_bubble=1 (freeze=0, flush=0): all fields load 0 and EXE_valid=0. Upstream stages are held by the hazard unit, not by this block.
- Otherwise: every EXE_x <= ID_x and EXE_valid <= 1. Latency from ID to EXE is exactly one cycle.
- flush together with insert_bubble: the flush result, which is identical, so no ambiguity.
- Forwarding mux: combinational, zero latency, evaluated on current sel inputs and registered values.
  - fwd_val_rn: sel_src1 = 2'b00 gives EXE_val_rn; 2'b01 gives MEM_alu_result; 2'b10 gives WB_value; 2'b11 gives EXE_val_rn.
  - fwd_val_rm: same mapping using sel_src2 and EXE_val_rm.
- EXE_src1/EXE_src2 are driven directly from registers so the forwarding path has no added logic depth.
- EXE_valid=0 slot: control outputs are 0, so no architectural effect. fwd_val_* may still be forwarded values and are don't-care.
- Reset deasserted mid-cycle: first load occurs at the next rising edge. Outputs stay 0 until then.
- No arithmetic; pure width-preserving copies.

Test Plan:
- Reset: load a non-zero instruction, assert rst asynchronously between edges -> all EXE_* and EXE_valid read 0 before the next edge.
- Normal load: ID_dst=4'h3, ID_val_rn=32'h1234_5678, ID_wb_en=1 -> one edge later EXE_dst=3, EXE_val_rn=32'h1234_5678, EXE_wb_en=1, EXE_valid=1.
- Freeze: registered EXE_pc=32'h10, then freeze=1 for 3 cycles with ID_pc changing -> EXE_pc stays 32'h10. After release, the next edge captures the current ID_pc.
- Freeze and flush asserted together: state held. Flush alone on the next edge -> EXE_wb_en=0, EXE_mem_w_en=0, EXE_b=0, EXE_valid=0.
- Bubble: insert_bubble=1 with ID_mem_r_en=1 -> EXE_mem_r_en=0 and EXE_valid=0. Deassert -> instruction captured on the following edge.
- Forwarding mux: EXE_val_rn=32'hA, MEM_alu_result=32'hB, WB_value=32'hC. Drive sel_src1 00/01/10/11 -> fwd_val_rn = A/B/C/A in the same cycle. Repeat for sel_src2 and fwd_val_rm.
